// File: rtl/seg_bin2bcd.sv
// rtl/seg_bin2bcd.sv - sequential shift-add-3 binary to packed BCD converter
// One shift per clock; results, leading-zero mask and overflow are published together.
module seg_bin2bcd #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [DIGITS-1:0]     lz_mask,
  output logic                  ovf
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_FINISH
  } state_t;

  state_t              state_q;
  logic [WIDTH-1:0]    shreg_q;
  logic [4*DIGITS-1:0] acc_q;
  logic [4*DIGITS-1:0] acc_adj;
  logic [4*DIGITS-1:0] acc_d;
  logic [CW-1:0]       count_q;
  logic                ovf_sticky_q;
  logic                done_q;
  logic [4*DIGITS-1:0] bcd_q;
  logic [DIGITS-1:0]   lz_q;
  logic [DIGITS-1:0]   lz_d;
  logic                ovf_q;
  logic                all_zero;

  always_comb begin
    acc_adj = acc_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (acc_q[4*i +: 4] >= 4'd5) begin
        acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
      end
    end
    // The corrected top-digit MSB falls off here; it is what ovf_sticky_q records.
    acc_d = {acc_adj[4*DIGITS-2:0], shreg_q[WIDTH-1]};
  end

  always_comb begin
    lz_d     = '0;
    all_zero = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      all_zero = all_zero & (acc_q[4*i +: 4] == 4'd0);
      lz_d[i]  = all_zero;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      shreg_q      <= '0;
      acc_q        <= '0;
      count_q      <= '0;
      ovf_sticky_q <= 1'b0;
      done_q       <= 1'b0;
      bcd_q        <= '0;
      lz_q         <= '0;
      ovf_q        <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            shreg_q      <= bin;
            acc_q        <= '0;
            ovf_sticky_q <= 1'b0;
            count_q      <= CW'(WIDTH);
            state_q      <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          acc_q        <= acc_d;
          shreg_q      <= {shreg_q[WIDTH-2:0], 1'b0};
          ovf_sticky_q <= ovf_sticky_q | acc_adj[4*DIGITS-1];
          count_q      <= count_q - CW'(1);
          if (count_q == CW'(1)) begin
            state_q <= S_FINISH;
          end
        end
        S_FINISH: begin
          bcd_q   <= acc_q;
          // A truncated value has no genuine leading zeros, so show every digit.
          lz_q    <= ovf_sticky_q ? '0 : lz_d;
          ovf_q   <= ovf_sticky_q;
          done_q  <= 1'b1;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy    = (state_q != S_IDLE);
  assign done    = done_q;
  assign bcd     = bcd_q;
  assign lz_mask = lz_q;
  assign ovf     = ovf_q;

endmodule

// File: tb/tb_seg_bin2bcd.sv
// tb/tb_seg_bin2bcd.sv - scoreboard bench for seg_bin2bcd (default and 10-bit/3-digit builds)
module tb_seg_bin2bcd;

  typedef struct packed {
    logic [19:0] bcd;
    logic [4:0]  lz;
    logic        ovf;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] bin = '0;
  logic        busy, done, ovf;
  logic [19:0] bcd;
  logic [4:0]  lz_mask;

  logic        start_s = 1'b0;
  logic [9:0]  bin_s = '0;
  logic        busy_s, done_s, ovf_s;
  logic [11:0] bcd_s;
  logic [2:0]  lz_mask_s;

  int   tests_run = 0;
  int   tests_failed = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  seg_bin2bcd dut (
    .clk(clk), .rst(rst), .start(start), .bin(bin),
    .busy(busy), .done(done), .bcd(bcd), .lz_mask(lz_mask), .ovf(ovf)
  );

  seg_bin2bcd #(.WIDTH(10), .DIGITS(3)) dut_s (
    .clk(clk), .rst(rst), .start(start_s), .bin(bin_s),
    .busy(busy_s), .done(done_s), .bcd(bcd_s), .lz_mask(lz_mask_s), .ovf(ovf_s)
  );

  // Decimal reference: value mod 10^nd, overflow when it does not fit.
  function automatic exp_t model(input int unsigned v, input int nd);
    exp_t        e;
    int unsigned lim = 1;
    int unsigned r;
    bit          seen = 1'b0;
    e = '0;
    for (int i = 0; i < nd; i++) lim = lim * 10;
    e.ovf = (v >= lim);
    r = v % lim;
    for (int i = 0; i < nd; i++) begin
      e.bcd[4*i +: 4] = 4'(r % 10);
      r = r / 10;
    end
    for (int i = nd - 1; i >= 1; i--) begin
      if (e.bcd[4*i +: 4] != 4'd0) seen = 1'b1;
      e.lz[i] = !seen && !e.ovf;
    end
    return e;
  endfunction

  task automatic wait_done_big(output bit got, output int lat, output int nbusy);
    got = 1'b0; lat = 0; nbusy = 0;
    while (!got && lat < 40) begin
      if (done === 1'b1) got = 1'b1;
      else begin
        if (busy === 1'b1) nbusy++;
        lat++;
        @(negedge clk);
      end
    end
  endtask

  task automatic wait_done_small(output bit got, output int lat);
    got = 1'b0; lat = 0;
    while (!got && lat < 40) begin
      if (done_s === 1'b1) got = 1'b1;
      else begin
        lat++;
        @(negedge clk);
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    tests_run++;
    if ({busy, done, bcd, lz_mask, ovf} !== 28'h0) begin
      tests_failed++;
      $display("FAIL reset_big: got %h required 0", {busy, done, bcd, lz_mask, ovf});
    end
    tests_run++;
    if ({busy_s, done_s, bcd_s, lz_mask_s, ovf_s} !== 18'h0) begin
      tests_failed++;
      $display("FAIL reset_small: got %h required 0", {busy_s, done_s, bcd_s, lz_mask_s, ovf_s});
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_zero;
    bit   got;
    int   lat, nb;
    exp_t e;
    bin = 16'd0; start = 1'b1; sb.push_back(model(0, 5));
    @(negedge clk);
    start = 1'b0;
    wait_done_big(got, lat, nb);
    tests_run++;
    if (!got || lat != 17) begin
      tests_failed++;
      $display("FAIL zero_latency: got %0d (seen=%0d) required 17", lat, got);
    end
    tests_run++;
    if (nb != 17 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL zero_busy: got %0d busy cycles, busy=%b in done cycle, required 17 and 0", nb, busy);
    end
    e = (sb.size() > 0) ? sb.pop_front() : '1;
    tests_run++;
    if (bcd !== e.bcd || lz_mask !== e.lz || ovf !== e.ovf) begin
      tests_failed++;
      $display("FAIL zero_result: got %h/%b/%b required %h/%b/%b", bcd, lz_mask, ovf, e.bcd, e.lz, e.ovf);
    end
    @(negedge clk);
    tests_run++;
    if (done !== 1'b0) begin
      tests_failed++;
      $display("FAIL zero_done_width: got done=%b required 0", done);
    end
  endtask

  task automatic test_values;
    int unsigned vals[7];
    bit          got;
    int          lat, nb;
    exp_t        e;
    vals = '{65535, 42, 10000, 9, $urandom_range(65535), $urandom_range(65535), $urandom_range(999)};
    foreach (vals[n]) begin
      bin = 16'(vals[n]); start = 1'b1; sb.push_back(model(vals[n], 5));
      @(negedge clk);
      start = 1'b0;
      wait_done_big(got, lat, nb);
      e = (sb.size() > 0) ? sb.pop_front() : '1;
      tests_run++;
      if (!got || lat != 17 || bcd !== e.bcd || lz_mask !== e.lz || ovf !== e.ovf) begin
        tests_failed++;
        $display("FAIL value_%0d: got lat=%0d %h/%b/%b required lat=17 %h/%b/%b",
                 vals[n], lat, bcd, lz_mask, ovf, e.bcd, e.lz, e.ovf);
      end
      repeat (2) @(negedge clk);
    end
  endtask

  task automatic test_small_ovf;
    int unsigned vals[5];
    bit          got;
    int          lat;
    exp_t        e;
    vals = '{1023, 999, 1000, 0, 7};
    foreach (vals[n]) begin
      bin_s = 10'(vals[n]); start_s = 1'b1; sb.push_back(model(vals[n], 3));
      @(negedge clk);
      start_s = 1'b0;
      wait_done_small(got, lat);
      e = (sb.size() > 0) ? sb.pop_front() : '1;
      tests_run++;
      if (!got || lat != 11 || bcd_s !== e.bcd[11:0] || lz_mask_s !== e.lz[2:0] || ovf_s !== e.ovf) begin
        tests_failed++;
        $display("FAIL small_%0d: got lat=%0d %h/%b/%b required lat=11 %h/%b/%b",
                 vals[n], lat, bcd_s, lz_mask_s, ovf_s, e.bcd[11:0], e.lz[2:0], e.ovf);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back;
    bit   got;
    int   lat, nb, extra;
    exp_t e;
    bin = 16'd12345; start = 1'b1; sb.push_back(model(12345, 5));
    @(negedge clk);
    repeat (5) @(negedge clk);
    bin = 16'd54321;
    wait_done_big(got, lat, nb);
    e = (sb.size() > 0) ? sb.pop_front() : '1;
    tests_run++;
    if (!got || lat + 5 != 17 || bcd !== e.bcd || lz_mask !== e.lz || ovf !== e.ovf) begin
      tests_failed++;
      $display("FAIL b2b_first: got lat=%0d %h required lat=17 %h", lat + 5, bcd, e.bcd);
    end
    sb.push_back(model(54321, 5));
    @(negedge clk);
    start = 1'b0;
    wait_done_big(got, lat, nb);
    e = (sb.size() > 0) ? sb.pop_front() : '1;
    tests_run++;
    if (!got || lat != 17 || bcd !== e.bcd || lz_mask !== e.lz || ovf !== e.ovf) begin
      tests_failed++;
      $display("FAIL b2b_second: got lat=%0d %h required lat=17 %h", lat, bcd, e.bcd);
    end
    extra = 0;
    repeat (20) begin
      @(negedge clk);
      if (done === 1'b1) extra++;
    end
    tests_run++;
    if (extra != 0) begin
      tests_failed++;
      $display("FAIL b2b_extra_done: got %0d pulses required 0", extra);
    end
  endtask

  task automatic test_reset_mid;
    bit   got;
    int   lat, nb, extra;
    exp_t e;
    bin = 16'd9999; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tests_run++;
    if ({busy, done, bcd, lz_mask, ovf} !== 28'h0) begin
      tests_failed++;
      $display("FAIL rst_mid_outputs: got %h required 0", {busy, done, bcd, lz_mask, ovf});
    end
    extra = 0;
    repeat (25) begin
      @(negedge clk);
      if (done === 1'b1) extra++;
    end
    tests_run++;
    if (extra != 0) begin
      tests_failed++;
      $display("FAIL rst_mid_no_done: got %0d pulses required 0", extra);
    end
    bin = 16'd9999; start = 1'b1; sb.push_back(model(9999, 5));
    @(negedge clk);
    start = 1'b0;
    wait_done_big(got, lat, nb);
    e = (sb.size() > 0) ? sb.pop_front() : '1;
    tests_run++;
    if (!got || lat != 17 || bcd !== e.bcd || lz_mask !== e.lz || ovf !== e.ovf) begin
      tests_failed++;
      $display("FAIL rst_mid_reconvert: got lat=%0d %h/%b/%b required lat=17 %h/%b/%b",
               lat, bcd, lz_mask, ovf, e.bcd, e.lz, e.ovf);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_zero();
    test_values();
    test_small_ovf();
    test_back_to_back();
    test_reset_mid();
    tests_run++;
    if (sb.size() != 0) begin
      tests_failed++;
      $display("FAIL scoreboard_drain: got %0d left required 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
